// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Package  : uart_pkg
// Summary  : Shared types and constants for the parametrised UART receiver.
// Revision : 1.0  initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BRK    = 3'd5
  } state_t;

  // Encoding 2'b11 is treated like PAR_NONE.
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Summary  : Show-ahead receive FIFO. A push into a full FIFO succeeds only
//            when a pop happens in the same cycle; a pop of an empty FIFO is
//            ignored. The head reads as zero while empty.
// Revision : 1.0  initial release
// ============================================================================
module uart_rx_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [DATA_W-1:0]             din,
  input  logic                          pop,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   cnt,
  output logic [DATA_W-1:0]             dout
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [PTR_W:0]    cnt_q, cnt_d;
  logic              do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (PTR_W+1)'(FIFO_DEPTH));
  assign cnt     = cnt_q;
  assign dout    = empty ? '0 : mem_q[rd_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Next-state for storage, pointers and occupancy
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_d = rd_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (PTR_W+1)'(1);
      2'b01:   cnt_d = cnt_q - (PTR_W+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_param
// Summary  : Parametrised UART receiver with per-frame latched configuration,
//            false-start rejection, sticky error flags, break handling, a
//            show-ahead receive FIFO and a masked match trigger.
// Revision : 1.0  initial release
// ============================================================================
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int BAUD_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          RX,
  input  logic [BAUD_W-1:0]             baud_cnt,
  input  logic [1:0]                    parity_mode,
  input  logic                          two_stop,
  input  logic                          rd_en,
  input  logic                          clr_err,
  input  logic [DATA_W-1:0]             match,
  input  logic [DATA_W-1:0]             mask,
  output logic [DATA_W-1:0]             rx_data,
  output logic                          rdy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun,
  output logic                          UARTtrig
);
  localparam int BIT_W = 4;
  localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_W - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  state_t                 state_q, state_d;
  logic [BAUD_W-1:0]      cnt_q, cnt_d, baud_q, baud_d, term;
  logic [1:0]             pmode_q, pmode_d;
  logic                   two_q, two_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic [DATA_W-1:0]      shreg_q, shreg_d;
  logic                   par_bad_q, par_bad_d, stop_low_q, stop_low_d;
  logic                   ferr_q, ferr_d, perr_q, perr_d, ovr_q, ovr_d, trig_q, trig_d;
  logic                   rxs, tick, par_en, frame_ok, set_ferr, set_perr;
  logic                   fifo_full, fifo_empty;

  assign rxs    = sync_q[SYNC_STAGES-1];
  assign par_en = (pmode_q == PAR_EVEN) || (pmode_q == PAR_ODD);
  assign tick   = (cnt_q == term);

  // Shift the raw pin through the synchroniser chain
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], RX};
  end

  // Half a bit period to reach the start-bit midpoint, full periods after
  always_comb begin
    term = baud_q - BAUD_W'(1);
    if (state_q == START) term = (baud_q >> 1) - BAUD_W'(1);
  end

  // Receive FSM: next state, datapath updates and frame verdict
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + BAUD_W'(1);
    baud_d     = baud_q;
    pmode_d    = pmode_q;
    two_d      = two_q;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    par_bad_d  = par_bad_q;
    stop_low_d = stop_low_q;
    frame_ok   = 1'b0;
    set_ferr   = 1'b0;
    set_perr   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rxs) begin
          baud_d     = baud_cnt;
          pmode_d    = parity_mode;
          two_d      = two_stop;
          bit_d      = '0;
          par_bad_d  = 1'b0;
          stop_low_d = 1'b0;
          state_d    = START;
        end
      end
      START: if (tick) begin
        cnt_d   = '0;
        bit_d   = '0;
        state_d = rxs ? IDLE : DATA;
      end
      DATA: if (tick) begin
        cnt_d   = '0;
        shreg_d = {rxs, shreg_q[DATA_W-1:1]};
        bit_d   = bit_q + BIT_W'(1);
        if (bit_q == LAST_DATA) begin
          bit_d   = '0;
          state_d = par_en ? PARITY : STOP;
        end
      end
      PARITY: if (tick) begin
        cnt_d     = '0;
        // Even mode wants XOR(data,bit)=0, odd mode wants 1
        par_bad_d = (^shreg_q) ^ rxs ^ (pmode_q == PAR_ODD);
        state_d   = STOP;
      end
      STOP: if (tick) begin
        cnt_d      = '0;
        bit_d      = bit_q + BIT_W'(1);
        stop_low_d = stop_low_q | ~rxs;
        if (bit_q == {{(BIT_W-1){1'b0}}, two_q}) begin
          state_d = IDLE;
          if (stop_low_q | ~rxs) begin
            set_ferr = 1'b1;
            state_d  = BRK;
          end else if (par_bad_q) begin
            set_perr = 1'b1;
          end else begin
            frame_ok = 1'b1;
          end
        end
      end
      BRK: begin
        cnt_d = '0;
        if (rxs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sticky flags (a set beats a same-cycle clear) and trigger pulse
  always_comb begin
    ferr_d = set_ferr | (ferr_q & ~clr_err);
    perr_d = set_perr | (perr_q & ~clr_err);
    ovr_d  = (frame_ok & fifo_full & ~rd_en) | (ovr_q & ~clr_err);
    trig_d = frame_ok & ((shreg_q | mask) == (match | mask));
  end

  // Receiver state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= '1;
      state_q    <= IDLE;
      cnt_q      <= '0;
      baud_q     <= '0;
      pmode_q    <= PAR_NONE;
      two_q      <= 1'b0;
      bit_q      <= '0;
      shreg_q    <= '0;
      par_bad_q  <= 1'b0;
      stop_low_q <= 1'b0;
      ferr_q     <= 1'b0;
      perr_q     <= 1'b0;
      ovr_q      <= 1'b0;
      trig_q     <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      baud_q     <= baud_d;
      pmode_q    <= pmode_d;
      two_q      <= two_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      par_bad_q  <= par_bad_d;
      stop_low_q <= stop_low_d;
      ferr_q     <= ferr_d;
      perr_q     <= perr_d;
      ovr_q      <= ovr_d;
      trig_q     <= trig_d;
    end
  end

  uart_rx_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (frame_ok),
    .din   (shreg_q),
    .pop   (rd_en),
    .full  (fifo_full),
    .empty (fifo_empty),
    .cnt   (fifo_cnt),
    .dout  (rx_data)
  );

  assign rdy        = ~fifo_empty;
  assign frame_err  = ferr_q;
  assign parity_err = perr_q;
  assign overrun    = ovr_q;
  assign UARTtrig   = trig_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_param
// Summary  : Directed self-checking bench for uart_rx_param (8-bit and 7-bit
//            instances) with a queue scoreboard of expected FIFO contents.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx_param;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] baud;
  logic [1:0]  pmode;
  logic        two_stop, clr_err;

  logic        rx8, rd8, rdy8, fe8, pe8, ov8, trig8;
  logic [7:0]  match8, mask8, d8;
  logic [2:0]  cnt8;
  logic        rx7, rd7, rdy7, fe7, pe7, ov7, trig7;
  logic [6:0]  match7, mask7, d7;
  logic [2:0]  cnt7;

  int          errors = 0;
  int          checks = 0;
  int          trig8_n = 0;
  int          trig7_n = 0;
  logic        last_trig;
  logic [8:0]  q8[$];
  logic [8:0]  q7[$];

  uart_rx_param #(.DATA_W(8), .FIFO_DEPTH(4), .BAUD_W(16), .SYNC_STAGES(2)) dut8 (
    .clk(clk), .rst(rst), .RX(rx8), .baud_cnt(baud), .parity_mode(pmode),
    .two_stop(two_stop), .rd_en(rd8), .clr_err(clr_err), .match(match8), .mask(mask8),
    .rx_data(d8), .rdy(rdy8), .fifo_cnt(cnt8), .frame_err(fe8), .parity_err(pe8),
    .overrun(ov8), .UARTtrig(trig8)
  );

  uart_rx_param #(.DATA_W(7), .FIFO_DEPTH(4), .BAUD_W(16), .SYNC_STAGES(2)) dut7 (
    .clk(clk), .rst(rst), .RX(rx7), .baud_cnt(baud), .parity_mode(pmode),
    .two_stop(two_stop), .rd_en(rd7), .clr_err(clr_err), .match(match7), .mask(mask7),
    .rx_data(d7), .rdy(rdy7), .fifo_cnt(cnt7), .frame_err(fe7), .parity_err(pe7),
    .overrun(ov7), .UARTtrig(trig7)
  );

  always #5 clk = ~clk;

  // Count trigger cycles; a single-cycle pulse adds exactly one
  always @(negedge clk) begin
    if (trig8 === 1'b1) trig8_n++;
    if (trig7 === 1'b1) trig7_n++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  // Compare the head with the scoreboard front, then pop it
  task automatic pop_chk(input bit w, input string tag);
    logic [8:0] e;
    logic [8:0] h;
    e = 'x;
    if (w) begin
      if (q7.size() != 0) e = q7.pop_front();
      h   = {2'b00, d7};
      rd7 = 1'b1;
    end else begin
      if (q8.size() != 0) e = q8.pop_front();
      h   = {1'b0, d8};
      rd8 = 1'b1;
    end
    chk(tag, h, e);
    @(negedge clk);
    rd7 = 1'b0;
    rd8 = 1'b0;
  endtask

  task automatic drain(input bit w, input string tag);
    for (int g = 0; g < 8; g++)
      if ((w ? rdy7 : rdy8) === 1'b1) pop_chk(w, tag);
    chk({tag, "_left"}, w ? q7.size() : q8.size(), 0);
  endtask

  // Serialise one frame using the configuration current at call time.
  // With rd_push set, rd_en is raised for the cycle whose edge writes the frame.
  task automatic send_frame(input bit w, input logic [8:0] d, input bit bad_par, input bit rd_push);
    logic [15:0] fr;
    logic        p;
    logic [8:0]  e;
    int          dw, nb, bp, fin;
    dw = w ? 7 : 8;
    bp = int'(baud);
    fr = '1;
    fr[0] = 1'b0;
    p = 1'b0;
    for (int i = 0; i < dw; i++) begin
      fr[1+i] = d[i];
      p ^= d[i];
    end
    nb = dw;
    if (pmode == 2'b01 || pmode == 2'b10) begin
      if (pmode == 2'b10) p = ~p;
      fr[1+dw] = p ^ bad_par;
      nb++;
    end
    nb += two_stop ? 2 : 1;
    fin = 3 + bp / 2 + bp * nb;
    for (int c = 0; c < bp * (nb + 1); c++) begin
      if (w) rx7 = fr[c / bp];
      else   rx8 = fr[c / bp];
      if (rd_push && c == fin - 1) begin
        e = 'x;
        if (w) begin
          if (q7.size() != 0) e = q7.pop_front();
          chk("rdpush_head", {2'b00, d7}, e);
          rd7 = 1'b1;
        end else begin
          if (q8.size() != 0) e = q8.pop_front();
          chk("rdpush_head", {1'b0, d8}, e);
          rd8 = 1'b1;
        end
      end else begin
        rd7 = 1'b0;
        rd8 = 1'b0;
      end
      @(negedge clk);
      if (c + 1 == fin) last_trig = w ? trig7 : trig8;
    end
    rd7 = 1'b0;
    rd8 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rx8 = 1'b1; rx7 = 1'b1; rd8 = 1'b0; rd7 = 1'b0; clr_err = 1'b0;
    baud = 16'd16; pmode = 2'b00; two_stop = 1'b0; last_trig = 1'b0;
    match8 = 8'hA0; mask8 = 8'h0F; match7 = 7'h7F; mask7 = 7'h00;
    idle(3);
    rst = 1'b0;
    idle(1);

    // Reset state
    chk("rst_rdy", rdy8, 0);
    chk("rst_data", d8, 0);
    chk("rst_cnt", cnt8, 0);
    chk("rst_ferr", fe8, 0);
    chk("rst_perr", pe8, 0);
    chk("rst_ovr", ov8, 0);
    chk("rst_trig", trig8, 0);

    // Valid 8N1 frame matching A0 with low nibble masked
    q8.push_back(9'h0A5);
    send_frame(0, 9'h0A5, 1'b0, 1'b0);
    chk("8n1_trig_edge", last_trig, 1);
    chk("8n1_trig_n", trig8_n, 1);
    chk("8n1_rdy", rdy8, 1);
    chk("8n1_cnt", cnt8, 1);
    drain(0, "8n1_data");
    chk("8n1_rdy_after", rdy8, 0);

    // Even parity: bad parity bit is rejected, then a good frame is accepted
    pmode = 2'b01; match8 = 8'h03; mask8 = 8'h00;
    send_frame(0, 9'h003, 1'b1, 1'b0);
    idle(4);
    chk("par_err", pe8, 1);
    chk("par_nopush", cnt8, 0);
    chk("par_notrig", trig8_n, 1);
    chk("par_ferr", fe8, 0);
    pulse_clr();
    chk("par_clr", pe8, 0);
    q8.push_back(9'h003);
    send_frame(0, 9'h003, 1'b0, 1'b0);
    chk("par_good_trig", trig8_n, 2);
    chk("par_good_perr", pe8, 0);
    drain(0, "par_good_data");

    // False start, then a frame that matches through the mask
    pmode = 2'b00; match8 = 8'hA0; mask8 = 8'h0F;
    rx8 = 1'b0; idle(5); rx8 = 1'b1; idle(48);
    chk("fs_cnt", cnt8, 0);
    chk("fs_ferr", fe8, 0);
    chk("fs_perr", pe8, 0);
    q8.push_back(9'h0AF);
    send_frame(0, 9'h0AF, 1'b0, 1'b0);
    chk("fs_next_trig", trig8_n, 3);
    drain(0, "fs_next_data");

    // Break: 20 bit times low
    rx8 = 1'b0; idle(15 * 16);
    chk("brk_ferr_early", fe8, 1);
    idle(5 * 16);
    rx8 = 1'b1; idle(32);
    chk("brk_ferr", fe8, 1);
    chk("brk_cnt", cnt8, 0);
    chk("brk_perr", pe8, 0);
    pulse_clr();
    q8.push_back(9'h05A);
    send_frame(0, 9'h05A, 1'b0, 1'b0);
    chk("brk_next_ferr", fe8, 0);
    chk("brk_next_trig", trig8_n, 3);
    drain(0, "brk_next_data");

    // Overrun: fifth frame into a full FIFO is dropped
    for (int i = 1; i <= 5; i++) begin
      if (i < 5) q8.push_back(9'(i));
      send_frame(0, 9'(i), 1'b0, 1'b0);
    end
    chk("ovr_cnt", cnt8, 4);
    chk("ovr_flag", ov8, 1);
    chk("ovr_head", d8, 8'h01);
    drain(0, "ovr_data");
    pulse_clr();
    chk("ovr_clr", ov8, 0);

    // Same again with a read coincident with the fifth write
    for (int i = 1; i <= 4; i++) begin
      q8.push_back(9'(i));
      send_frame(0, 9'(i), 1'b0, 1'b0);
    end
    q8.push_back(9'h005);
    send_frame(0, 9'h005, 1'b0, 1'b1);
    idle(2);
    chk("ovr_rd_flag", ov8, 0);
    chk("ovr_rd_cnt", cnt8, 4);
    drain(0, "ovr_rd_data");

    // 7-bit, odd parity, two stop bits, back to back; config changed mid-frame
    pmode = 2'b10; two_stop = 1'b1;
    q7.push_back(9'h07F);
    q7.push_back(9'h000);
    send_frame(1, 9'h07F, 1'b0, 1'b0);
    fork
      send_frame(1, 9'h000, 1'b0, 1'b0);
      begin
        idle(40);
        pmode = 2'b00; two_stop = 1'b0; baud = 16'd9;
      end
    join
    baud = 16'd16;
    chk("mix_cnt", cnt7, 2);
    chk("mix_perr", pe7, 0);
    chk("mix_ferr", fe7, 0);
    chk("mix_trig", trig7_n, 1);
    pop_chk(1, "mix_first");
    chk("mix_left", cnt7, 1);

    // Reset in the middle of a third frame
    rx7 = 1'b0; idle(3 * 16);
    rst = 1'b1; rx7 = 1'b1; idle(2);
    rst = 1'b0;
    q7.delete();
    q8.delete();
    idle(200);
    chk("rst2_rdy7", rdy7, 0);
    chk("rst2_cnt7", cnt7, 0);
    chk("rst2_data7", d7, 0);
    chk("rst2_ferr7", fe7, 0);
    chk("rst2_perr7", pe7, 0);
    chk("rst2_ovr7", ov7, 0);
    chk("rst2_trig7", trig7, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver for the logic-analyser trigger path. It generalises the fixed 8N1 receiver to:
- configurable data width, parity and stop bits;
- a runtime bit period, latched per frame;
- false-start rejection, error flags and break handling;
- a show-ahead receive FIFO;
- a masked match trigger.

It sits between the synchronised probe/RX pin and the trigger/command logic.

## Interface
- DATA_W, 8, data bits per frame, legal 5..9
- FIFO_DEPTH, 4, receive FIFO entries, power of two, >= 2
- BAUD_W, 16, width of the bit-period input
- SYNC_STAGES, 2, RX synchroniser flops, >= 2
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- RX  in  1  serial input, idle high, LSB first
- baud_cnt  in  BAUD_W  bit period in clk cycles, >= 8; latched at start-bit detection
- parity_mode  in  2  00 none, 01 even, 10 odd, 11 none; latched at start-bit detection
- two_stop  in  1  1 = two stop bits expected; latched at start-bit detection
- rd_en  in  1  pop FIFO head; ignored when empty
- clr_err  in  1  clears sticky error flags
- match  in  DATA_W  trigger compare value
- mask  in  DATA_W  1 = don't-care bit
- rx_data  out  DATA_W  FIFO head (show-ahead); valid when rdy
- rdy  out  1  FIFO not empty
- fifo_cnt  out  $clog2(FIFO_DEPTH)+1  occupancy
- frame_err  out  1  sticky: a stop sample was low
- parity_err  out  1  sticky: parity mismatch
- overrun  out  1  sticky: valid frame dropped because FIFO full
- UARTtrig  out  1  one-cycle pulse on a matching valid frame

## Operation
- RX passes through SYNC_STAGES flops, all reset to 1; every sample uses the synchronised value rxs.
- Baud counter counts up from 0 and clears on each tick.
  - Terminal value in START: (baud_cnt_l>>1)-1.
  - Terminal value in all other sampling states: baud_cnt_l-1.
- FSM states:
  - IDLE: rxs==0 → latch config, clear counters → START.
  - START: on tick, rxs==1 → IDLE (false start, no flags); else → DATA.
  - DATA: on each tick, shift rxs in from the MSB side (LSB first). After DATA_W samples → PARITY if parity enabled, else STOP.
  - PARITY: on tick, compute even mode as XOR(data)^bit==0; odd mode requires 1 → STOP.
  - STOP: sample 1 or 2 (two_stop) stop bits, then evaluate the frame:
    - any stop sample low: set frame_err, discard → BRK;
    - else parity bad: set parity_err, discard → IDLE;
    - else the frame is valid → IDLE.
  - BRK: wait for rxs==1 → IDLE. Sets no further flags.
- Valid frame handling:
  - Push to FIFO, or set overrun if full; the FIFO is unchanged on overrun.
  - UARTtrig=1 if ((data|mask)==(match|mask)), independent of overrun.
- FIFO: pop when rd_en && rdy. Push+pop in the same cycle:
  - when full: both succeed, no overrun;
  - when empty: push succeeds, the pop is ignored.
- Error flags: clr_err clears them; a set in the same cycle as clr_err wins.
- Inputs changed mid-frame (baud_cnt, parity_mode, two_stop) do not affect the current frame.

## Timing
- Reset state:
  - FSM in IDLE, synchroniser all 1, counters 0, FIFO empty.
  - rx_data=0, rdy=0, fifo_cnt=0.
  - All error flags 0, UARTtrig=0.
- RX falling edge → START entry: SYNC_STAGES+1 cycles.
- First sample at the start-bit midpoint; each later sample one baud_cnt_l period after the previous one.
- Final stop-sample tick at edge N:
  - the FIFO write and the UARTtrig register occur at edge N;
  - rdy, fifo_cnt and UARTtrig are visible after edge N;
  - UARTtrig drops after edge N+1.
- FSM returns to IDLE at the stop-bit midpoint. A start bit following immediately is detected without loss.
- rd_en at edge M: the new head is presented and fifo_cnt decrements after M.
- rst asserted mid-frame: immediate return to the reset state. The partial frame is lost and no flag is set.

## Structure
- Package uart_pkg:
  - state_t enum {IDLE, START, DATA, PARITY, STOP, BRK};
  - parity-mode localparams PAR_NONE, PAR_EVEN, PAR_ODD.
- Sub-module uart_rx_fifo: synchronous show-ahead FIFO with parameters DATA_W and FIFO_DEPTH, ports push/pop/full/empty/cnt/dout, same clk/rst.
- Top holds the synchroniser, baud/bit counters, FSM, error flags and trigger.

## Test plan
- Valid 8N1 frame: DATA_W=8, baud_cnt=16, send 0xA5 with match=0xA0, mask=0x0F → one UARTtrig pulse; rdy=1; rx_data=0xA5; fifo_cnt=1; rd_en → rdy=0.
- Parity error: parity_mode=01, send 0x03 with parity bit 1 → parity_err=1, no push, no trig. clr_err → 0. The next correct frame is accepted.
- False start: RX low for 5 cycles at baud 16 → FSM returns to IDLE; no push, no flags.
- Break: RX held low for 20 bit times → frame_err=1, no push. FSM stays in BRK until RX high, then receives 0x5A correctly.
- Overrun:
  - FIFO_DEPTH=4, five frames 0x01..0x05 with no reads → fifo_cnt=4, overrun=1, rx_data=0x01;
  - repeat with rd_en coincident with the fifth push → no overrun.
- Mixed mode and reset: DATA_W=7, odd parity, two_stop=1, back-to-back 0x7F, 0x00 → both pushed in order. Assert rst mid-third frame → all outputs return to reset values.
